tuple_extract: RTL

Upstream stage of the flow-lookup block: parses a GMII receive byte stream per port and builds the 96-bit tuple {dst MAC, src MAC}. Drives the lookup req/ack handshake and latches the returned 4-bit forwarding bitmap as a one-cycle result for the downstream switch fabric. One instance sits per port, between the GMII RX interface and the lookup stage.

---
 rtl/tuple_extract_pkg.sv | 20 ++
 rtl/sat_counter.sv | 37 +++
 rtl/tuple_extract.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/tuple_extract_pkg.sv
// Shared definitions for the tuple extractor.
// The parser FSM state encoding, the GMII framing bytes and the tuple
// geometry (12 address bytes forming a 96-bit {dst MAC, src MAC} tuple).
package tuple_extract_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_ADDR,
    ST_WAIT_ACK,
    ST_DRAIN
  } state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         ADDR_BYTES    = 12;
  localparam int         TUPLE_W       = 96;
  localparam int         IDX_W         = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset, clears the count
//   inc_i   number of events this cycle (0..3)
//   cnt_o   current count; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [1:0]   inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W:0]   sum;

  // One extra bit catches the carry out so we can clamp rather than wrap.
  always_comb begin
    sum   = {1'b0, cnt_q} + (W+1)'(inc_i);
    cnt_d = sum[W] ? {W{1'b1}} : sum[W-1:0];
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tuple_extract.sv
// Per-port GMII receive parser feeding the flow-lookup stage.
// Extracts {dst MAC, src MAC} from each frame, runs the req/ack lookup
// handshake and presents the forwarding bitmap as a one-cycle result.
// Ports:
//   sys_clk, sys_rst_n      clock / asynchronous active-low reset
//   gmii_rx_dv, gmii_rxd    GMII receive stream (synchronous to sys_clk)
//   req, tuple              lookup request (level) and 96-bit key
//   ack, fwd_port           lookup acknowledge and returned bitmap
//   res_valid, res_port,    one-cycle result pulse, bitmap, and timeout flag
//   res_drop
//   cnt_runt, cnt_drop      saturating counters: runts/bad preambles, and
//                           frames lost to ack timeout or overrun
module tuple_extract
  import tuple_extract_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             gmii_rx_dv,
  input  logic [7:0]       gmii_rxd,
  output logic             req,
  output logic [95:0]      tuple,
  input  logic             ack,
  input  logic [3:0]       fwd_port,
  output logic             res_valid,
  output logic [3:0]       res_port,
  output logic             res_drop,
  output logic [CNT_W-1:0] cnt_runt,
  output logic [CNT_W-1:0] cnt_drop
);

  localparam logic [7:0]       TO_LAST  = 8'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ADDR_BYTES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   byteIdx_q, byteIdx_d;
  logic [7:0]         toCnt_q, toCnt_d;
  logic               req_q, req_d;
  logic [TUPLE_W-1:0] tuple_q, tuple_d;
  logic               resValid_q, resValid_d;
  logic [3:0]         resPort_q, resPort_d;
  logic               resDrop_q, resDrop_d;
  logic               rxDvPrev_q;
  logic [1:0]         runtInc;
  logic [1:0]         dropInc;

  // Next-state and output decode for the frame parser / lookup handshake.
  always_comb begin
    state_d    = state_q;
    byteIdx_d  = byteIdx_q;
    toCnt_d    = toCnt_q;
    req_d      = req_q;
    tuple_d    = tuple_q;
    resValid_d = 1'b0;
    resPort_d  = resPort_q;
    resDrop_d  = resDrop_q;
    runtInc    = 2'd0;
    dropInc    = 2'd0;

    case (state_q)
      ST_IDLE: begin
        if (gmii_rx_dv) begin
          if (gmii_rxd == PREAMBLE_BYTE) begin
            state_d = ST_PREAMBLE;
          end else begin
            runtInc = 2'd1;
            state_d = ST_DRAIN;
          end
        end
      end

      ST_PREAMBLE: begin
        if (!gmii_rx_dv) begin
          runtInc = 2'd1;
          state_d = ST_IDLE;
        end else if (gmii_rxd == SFD_BYTE) begin
          byteIdx_d = '0;
          state_d   = ST_ADDR;
        end else if (gmii_rxd != PREAMBLE_BYTE) begin
          runtInc = 2'd1;
          state_d = ST_DRAIN;
        end
      end

      ST_ADDR: begin
        if (!gmii_rx_dv) begin
          runtInc = 2'd1;
          state_d = ST_IDLE;
        end else begin
          // Byte idx lands in tuple[95-8*idx -: 8]; constant bases keep
          // this a plain byte-enable mux.
          for (int i = 0; i < ADDR_BYTES; i++) begin
            if (byteIdx_q == IDX_W'(i)) begin
              tuple_d[TUPLE_W-1-8*i -: 8] = gmii_rxd;
            end
          end
          if (byteIdx_q == IDX_LAST) begin
            byteIdx_d = '0;
            toCnt_d   = '0;
            req_d     = 1'b1;
            state_d   = ST_WAIT_ACK;
          end else begin
            byteIdx_d = byteIdx_q + 1'b1;
          end
        end
      end

      ST_WAIT_ACK: begin
        // A new frame starting while the lookup is outstanding cannot be
        // parsed; count it and let DRAIN swallow it afterwards.
        if (gmii_rx_dv && !rxDvPrev_q) begin
          dropInc = dropInc + 2'd1;
        end
        if (ack) begin
          req_d      = 1'b0;
          resValid_d = 1'b1;
          resPort_d  = fwd_port;
          resDrop_d  = 1'b0;
          state_d    = gmii_rx_dv ? ST_DRAIN : ST_IDLE;
        end else if (toCnt_q == TO_LAST) begin
          req_d      = 1'b0;
          resValid_d = 1'b1;
          resPort_d  = 4'd0;
          resDrop_d  = 1'b1;
          dropInc    = dropInc + 2'd1;
          state_d    = gmii_rx_dv ? ST_DRAIN : ST_IDLE;
        end else begin
          toCnt_d = toCnt_q + 8'd1;
        end
      end

      ST_DRAIN: begin
        if (!gmii_rx_dv) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      byteIdx_q  <= '0;
      toCnt_q    <= '0;
      req_q      <= 1'b0;
      tuple_q    <= '0;
      resValid_q <= 1'b0;
      resPort_q  <= 4'd0;
      resDrop_q  <= 1'b0;
      rxDvPrev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byteIdx_q  <= byteIdx_d;
      toCnt_q    <= toCnt_d;
      req_q      <= req_d;
      tuple_q    <= tuple_d;
      resValid_q <= resValid_d;
      resPort_q  <= resPort_d;
      resDrop_q  <= resDrop_d;
      rxDvPrev_q <= gmii_rx_dv;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_runt (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .inc_i  (runtInc),
    .cnt_o  (cnt_runt)
  );

  sat_counter #(.W(CNT_W)) u_cnt_drop (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .inc_i  (dropInc),
    .cnt_o  (cnt_drop)
  );

  assign req       = req_q;
  assign tuple     = tuple_q;
  assign res_valid = resValid_q;
  assign res_port  = resPort_q;
  assign res_drop  = resDrop_q;

endmodule
